// File: rtl/alu_00_if.sv
// -----------------------------------------------------------------------------
// alu_00_if
// Operand/result bundle for the alu_00 registered integer ALU.
//   a      4   operand A (also the shift source)
//   b      4   operand B
//   shamt  2   shift amount 0..3 for SLA/SRA/SRL
//   funct  4   operation select
//   out    32  signed result, registered inside the ALU
// Modports:
//   master : drives a/b/shamt/funct, observes out (datapath controller, bench)
//   slave  : the ALU itself
// -----------------------------------------------------------------------------
interface alu_00_if;
  logic        [3:0]  a;
  logic        [3:0]  b;
  logic        [1:0]  shamt;
  logic        [3:0]  funct;
  logic signed [31:0] out;

  modport master (output a, output b, output shamt, output funct, input out);
  modport slave  (input a, input b, input shamt, input funct, output out);
endinterface

// File: rtl/alu_00.sv
// -----------------------------------------------------------------------------
// alu_00
// Small registered integer ALU: two 4-bit operands are extended to 32 bits,
// one of nine operations is selected by funct, and the 32-bit signed result is
// captured into out on every rising clk edge (1-cycle latency, no enable).
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous, active-high reset; forces out=0 while high
//   bus  slave modport of alu_00_if (a, b, shamt, funct in; out registered)
// funct: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 SLA, 7 SRA, 8 SRL,
//        9..15 reserved -> 0. All arithmetic wraps modulo 2^32.
// Configuration macro ALU_00_SIGN_EXT_EN:
//   undefined (default) - operands zero-extended (range 0..15); SRA == SRL.
//   defined             - operands sign-extended from bit 3 (range -8..7).
// -----------------------------------------------------------------------------
module alu_00 (
  input  logic    clk,
  input  logic    rst,
  alu_00_if.slave bus
);

  localparam logic [3:0] FUNCT_ADD = 4'd0;
  localparam logic [3:0] FUNCT_SUB = 4'd1;
  localparam logic [3:0] FUNCT_AND = 4'd2;
  localparam logic [3:0] FUNCT_OR  = 4'd3;
  localparam logic [3:0] FUNCT_XOR = 4'd4;
  localparam logic [3:0] FUNCT_NOT = 4'd5;
  localparam logic [3:0] FUNCT_SLA = 4'd6;
  localparam logic [3:0] FUNCT_SRA = 4'd7;
  localparam logic [3:0] FUNCT_SRL = 4'd8;

  // Widen a 4-bit operand to the 32-bit working width.
  function automatic logic signed [31:0] extend_operand(input logic [3:0] v);
`ifdef ALU_00_SIGN_EXT_EN
    return {{28{v[3]}}, v};
`else
    return {28'd0, v};
`endif
  endfunction

  logic signed [31:0] op_a_s;
  logic signed [31:0] op_b_s;
  logic signed [31:0] result_s;
  logic signed [31:0] out_r;

  assign op_a_s = extend_operand(bus.a);
  assign op_b_s = extend_operand(bus.b);

  // Operation select; op_a_s is signed so >>> fills from bit 31 while >>
  // always fills with zeros.
  always_comb begin
    result_s = 32'sd0;
    case (bus.funct)
      FUNCT_ADD: result_s = op_a_s + op_b_s;
      FUNCT_SUB: result_s = op_a_s - op_b_s;
      FUNCT_AND: result_s = op_a_s & op_b_s;
      FUNCT_OR:  result_s = op_a_s | op_b_s;
      FUNCT_XOR: result_s = op_a_s ^ op_b_s;
      FUNCT_NOT: result_s = ~op_a_s;
      FUNCT_SLA: result_s = op_a_s <<< bus.shamt;
      FUNCT_SRA: result_s = op_a_s >>> bus.shamt;
      FUNCT_SRL: result_s = op_a_s >> bus.shamt;
      default:   result_s = 32'sd0;
    endcase
  end

  // Result register; reset clears it immediately, independent of clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= 32'sd0;
    end else begin
      out_r <= result_s;
    end
  end

  assign bus.out = out_r;

endmodule

// File: tb/tb_alu_00.sv
// -----------------------------------------------------------------------------
// tb_alu_00
// Directed-vector bench for alu_00. Stimulus pushes the hand-computed result of
// each vector into a queue; a monitor pops and compares on the falling edge
// after the capturing rising edge. Reset and hold-until-edge behaviour are
// checked inline at instants between edges.
// -----------------------------------------------------------------------------
module tb_alu_00;

  typedef struct {
    logic signed [31:0] value;
    string              name;
  } exp_t;

  logic clk;
  logic rst;
  alu_00_if bus ();

  alu_00 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t exp_q[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inline comparison used for the between-edge checks.
  task automatic check_now(input string nm, input logic signed [31:0] want);
    checks++;
    if (bus.out !== want) begin
      errors++;
      $display("FAIL %s: out=%0d (0x%08h) expected %0d (0x%08h)",
               nm, bus.out, bus.out, want, want);
    end
  endtask

  // Drive one vector just after a falling edge and queue its expected result.
  task automatic apply(input logic [3:0] f, input logic [3:0] av,
                       input logic [3:0] bv, input logic [1:0] sh,
                       input logic signed [31:0] want, input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    bus.funct = f;
    bus.a     = av;
    bus.b     = bv;
    bus.shamt = sh;
    e.value   = want;
    e.name    = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: out is valid every falling edge after a capture.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.out !== e.value) begin
        errors++;
        $display("FAIL %s: out=%0d (0x%08h) expected %0d (0x%08h)",
                 e.name, bus.out, bus.out, e.value, e.value);
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.a     = 4'd0;
    bus.b     = 4'd0;
    bus.shamt = 2'd0;
    bus.funct = 4'd0;
    #1;
    check_now("reset_initial", 32'sd0);
    @(negedge clk);
    check_now("reset_held", 32'sd0);
    #1;
    rst = 1'b0;

`ifdef ALU_00_SIGN_EXT_EN
    apply(4'd0, 4'd12, 4'd3,  2'd3, -32'sd1,          "add_12_3");
    apply(4'd1, 4'd12, 4'd3,  2'd0, -32'sd7,          "sub_12_3");
    apply(4'd2, 4'd12, 4'd3,  2'd0,  32'sd0,          "and_12_3");
    apply(4'd3, 4'd12, 4'd3,  2'd0, -32'sd1,          "or_12_3");
    apply(4'd4, 4'd12, 4'd3,  2'd0, -32'sd1,          "xor_12_3");
    apply(4'd5, 4'd12, 4'd3,  2'd0,  32'sd3,          "not_12");
    apply(4'd6, 4'd12, 4'd3,  2'd0, -32'sd4,          "sla_12_sh0");
    apply(4'd6, 4'd12, 4'd3,  2'd3, -32'sd32,         "sla_12_sh3");
    apply(4'd7, 4'd12, 4'd3,  2'd2, -32'sd1,          "sra_12_sh2");
    apply(4'd8, 4'd12, 4'd3,  2'd2,  32'sd1073741823, "srl_12_sh2");
    apply(4'd1, 4'd3,  4'd12, 2'd0,  32'sd7,          "sub_3_12");
    apply(4'd0, 4'd15, 4'd15, 2'd0, -32'sd2,          "add_15_15");
    apply(4'd6, 4'd15, 4'd0,  2'd3, -32'sd8,          "sla_15_sh3");
    apply(4'd7, 4'd9,  4'd0,  2'd1, -32'sd4,          "sra_9_sh1");
    apply(4'd4, 4'd10, 4'd5,  2'd0, -32'sd1,          "xor_10_5");
    apply(4'd2, 4'd10, 4'd6,  2'd0,  32'sd2,          "and_10_6");
`else
    apply(4'd0, 4'd12, 4'd3,  2'd3,  32'sd15,         "add_12_3");
    apply(4'd1, 4'd12, 4'd3,  2'd0,  32'sd9,          "sub_12_3");
    apply(4'd2, 4'd12, 4'd3,  2'd0,  32'sd0,          "and_12_3");
    apply(4'd3, 4'd12, 4'd3,  2'd0,  32'sd15,         "or_12_3");
    apply(4'd4, 4'd12, 4'd3,  2'd0,  32'sd15,         "xor_12_3");
    apply(4'd5, 4'd12, 4'd3,  2'd0, -32'sd13,         "not_12");
    apply(4'd6, 4'd12, 4'd3,  2'd0,  32'sd12,         "sla_12_sh0");
    apply(4'd6, 4'd12, 4'd3,  2'd3,  32'sd96,         "sla_12_sh3");
    apply(4'd7, 4'd12, 4'd3,  2'd2,  32'sd3,          "sra_12_sh2");
    apply(4'd8, 4'd12, 4'd3,  2'd2,  32'sd3,          "srl_12_sh2");
    apply(4'd1, 4'd3,  4'd12, 2'd0, -32'sd9,          "sub_3_12");
    apply(4'd0, 4'd15, 4'd15, 2'd0,  32'sd30,         "add_15_15");
    apply(4'd6, 4'd15, 4'd0,  2'd3,  32'sd120,        "sla_15_sh3");
    apply(4'd7, 4'd9,  4'd0,  2'd1,  32'sd4,          "sra_9_sh1");
    apply(4'd4, 4'd10, 4'd5,  2'd0,  32'sd15,         "xor_10_5");
    apply(4'd2, 4'd10, 4'd6,  2'd0,  32'sd2,          "and_10_6");
`endif
    apply(4'd9,  4'd12, 4'd3, 2'd1, 32'sd0, "reserved_9");
    apply(4'd15, 4'd12, 4'd3, 2'd1, 32'sd0, "reserved_15");

    // Latency: ADD then SUB; out holds the ADD result until the next edge.
`ifdef ALU_00_SIGN_EXT_EN
    apply(4'd0, 4'd12, 4'd3, 2'd0, -32'sd1, "lat_add");
    apply(4'd1, 4'd12, 4'd3, 2'd0, -32'sd7, "lat_sub");
    #1;
    check_now("lat_hold", -32'sd1);
`else
    apply(4'd0, 4'd12, 4'd3, 2'd0, 32'sd15, "lat_add");
    apply(4'd1, 4'd12, 4'd3, 2'd0, 32'sd9,  "lat_sub");
    #1;
    check_now("lat_hold", 32'sd15);
`endif

    // Asynchronous reset mid-cycle with a nonzero result on out.
    apply(4'd0, 4'd7, 4'd7, 2'd0, 32'sd14, "pre_reset_add");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_now("reset_async", 32'sd0);
    @(negedge clk);
    check_now("reset_hold_edge1", 32'sd0);
    @(negedge clk);
    check_now("reset_hold_edge2", 32'sd0);

    // First edge after release loads the then-current result.
    #1;
    rst = 1'b0;
    apply(4'd3, 4'd5, 4'd10, 2'd0, 32'sd15, "post_reset_or");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4; i++) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
